// File: rtl/uart_work_framer.sv
// Byte-level framer: checksummed work/abort command frames in, nonce reply frames out.
// Optional macro FRAMER_ACK_EN adds an ack/nack reply for every completed RX frame.
module uart_work_framer #(
    parameter int unsigned HEADER_BYTES   = 80,
    parameter int unsigned NONCE_BYTES    = 4,
    parameter int unsigned RESULT_DEPTH   = 4,
    parameter int unsigned TIMEOUT_CYCLES = 5000000
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [7:0]                rx_data,
    input  logic                      rx_valid,
    output logic [HEADER_BYTES*8-1:0] header_data,
    output logic                      work_valid,
    output logic                      abort,
    input  logic [NONCE_BYTES*8-1:0]  nonce_in,
    input  logic                      nonce_valid,
    output logic [7:0]                tx_data,
    output logic                      tx_valid,
    input  logic                      tx_ready,
    output logic [15:0]               frame_err_count,
    output logic                      result_overflow
);
    localparam int unsigned HW = HEADER_BYTES * 8;
    localparam int unsigned NW = NONCE_BYTES * 8;
    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int unsigned IW = $clog2(HEADER_BYTES + 1);
    localparam int unsigned AW = $clog2(RESULT_DEPTH);
    localparam int unsigned DW = $clog2(NONCE_BYTES + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(HEADER_BYTES - 1);
    localparam logic [AW:0]   FIFO_FULL = (AW + 1)'(RESULT_DEPTH);

    typedef enum logic [1:0] {RX_IDLE, RX_CMD, RX_PAYLOAD, RX_CSUM} rx_state_t;
    typedef enum logic [2:0] {TX_IDLE, TX_SYNC, TX_CMD, TX_DATA, TX_CSUM} tx_state_t;

    rx_state_t        r_rx_state;
    logic [7:0]       r_cmd;
    logic [7:0]       r_rx_csum;
    logic [IW-1:0]    r_idx;
    logic [HW-1:0]    r_shadow;
    logic [TW-1:0]    r_tmo;
    logic [15:0]      r_err;

    logic [NW-1:0]    r_fifo [RESULT_DEPTH];
    logic [AW-1:0]    r_wp;
    logic [AW-1:0]    r_rp;
    logic [AW:0]      r_cnt;

    tx_state_t        r_tx_state;
    logic [NW-1:0]    r_tx_shift;
    logic [7:0]       r_tx_cmd;
    logic [7:0]       r_tx_csum;
    logic [DW-1:0]    r_tx_cnt;

    logic w_tmo_hit, w_cmd_bad, w_csum_ok, w_csum_bad, w_rx_err;
    logic w_full, w_empty, w_push, w_pop, w_ack_hold;

    assign w_tmo_hit  = (r_rx_state != RX_IDLE) && !rx_valid && (r_tmo == TMO_LAST);
    assign w_cmd_bad  = (r_rx_state == RX_CMD) && rx_valid && (rx_data != 8'h01) && (rx_data != 8'h02);
    assign w_csum_ok  = (rx_data == r_rx_csum);
    assign w_csum_bad = (r_rx_state == RX_CSUM) && rx_valid && !w_csum_ok;
    assign w_rx_err   = w_tmo_hit || w_cmd_bad || w_csum_bad;
    assign frame_err_count = r_err;

`ifdef FRAMER_ACK_EN
    logic       r_ack_req, r_ack_good, r_ack_pend, r_ack_pgood;
    logic [7:0] r_ack_cmd, r_ack_pcmd;
    logic       w_ack_take;
    logic [7:0] w_ack_data;

    assign w_ack_hold = r_ack_pend;
    assign w_ack_take = (r_tx_state == TX_IDLE) && tx_ready && r_ack_pend;
    assign w_ack_data = r_ack_pgood ? r_ack_pcmd : 8'h00;

    // A fresh completion overwrites a pending ack that TX has not yet started.
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_ack_pend  <= 1'b0;
            r_ack_pgood <= 1'b0;
            r_ack_pcmd  <= '0;
        end else if (r_ack_req) begin
            r_ack_pend  <= 1'b1;
            r_ack_pgood <= r_ack_good;
            r_ack_pcmd  <= r_ack_cmd;
        end else if (w_ack_take) begin
            r_ack_pend  <= 1'b0;
        end
    end
`else
    assign w_ack_hold = 1'b0;
`endif

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_rx_state  <= RX_IDLE;
            r_cmd       <= '0;
            r_rx_csum   <= '0;
            r_idx       <= '0;
            r_shadow    <= '0;
            r_tmo       <= '0;
            r_err       <= '0;
            header_data <= '0;
            work_valid  <= 1'b0;
            abort       <= 1'b0;
`ifdef FRAMER_ACK_EN
            r_ack_req   <= 1'b0;
            r_ack_good  <= 1'b0;
            r_ack_cmd   <= '0;
`endif
        end else begin
            work_valid <= 1'b0;
            abort      <= 1'b0;
`ifdef FRAMER_ACK_EN
            r_ack_req  <= w_rx_err || ((r_rx_state == RX_CSUM) && rx_valid && w_csum_ok);
            r_ack_good <= !w_rx_err;
            r_ack_cmd  <= r_cmd;
`endif
            if (r_rx_state == RX_IDLE || rx_valid || w_tmo_hit)
                r_tmo <= '0;
            else
                r_tmo <= r_tmo + TW'(1);

            if (w_tmo_hit) begin
                r_rx_state <= RX_IDLE;
            end else if (rx_valid) begin
                unique case (r_rx_state)
                    RX_IDLE: if (rx_data == 8'hAA) r_rx_state <= RX_CMD;
                    RX_CMD: begin
                        r_cmd     <= rx_data;
                        r_rx_csum <= rx_data;
                        r_idx     <= '0;
                        if (rx_data == 8'h01)      r_rx_state <= RX_PAYLOAD;
                        else if (rx_data == 8'h02) r_rx_state <= RX_CSUM;
                        else                       r_rx_state <= RX_IDLE;
                    end
                    RX_PAYLOAD: begin
                        r_shadow  <= (r_shadow << 8) | HW'(rx_data);
                        r_rx_csum <= r_rx_csum ^ rx_data;
                        r_idx     <= r_idx + IW'(1);
                        if (r_idx == IDX_LAST) r_rx_state <= RX_CSUM;
                    end
                    RX_CSUM: begin
                        if (w_csum_ok) begin
                            if (r_cmd == 8'h01) begin
                                header_data <= r_shadow;
                                work_valid  <= 1'b1;
                            end else begin
                                abort <= 1'b1;
                            end
                        end
                        r_rx_state <= RX_IDLE;
                    end
                    default: r_rx_state <= RX_IDLE;
                endcase
            end

            if (w_rx_err && (r_err != 16'hFFFF)) r_err <= r_err + 16'd1;
        end
    end

    // A frame is opened only while the transmitter reports ready, so a stalled
    // transmitter leaves every queued nonce inside the FIFO.
    assign w_full  = (r_cnt == FIFO_FULL);
    assign w_empty = (r_cnt == '0);
    assign w_pop   = (r_tx_state == TX_IDLE) && tx_ready && !w_empty && !w_ack_hold;
    assign w_push  = nonce_valid && (!w_full || w_pop);

    always_ff @(posedge clock) begin
        if (w_push) r_fifo[r_wp] <= nonce_in;
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_wp            <= '0;
            r_rp            <= '0;
            r_cnt           <= '0;
            result_overflow <= 1'b0;
        end else begin
            if (w_push) r_wp <= r_wp + AW'(1);
            if (w_pop)  r_rp <= r_rp + AW'(1);
            if (w_push && !w_pop)      r_cnt <= r_cnt + (AW + 1)'(1);
            else if (!w_push && w_pop) r_cnt <= r_cnt - (AW + 1)'(1);
            if (nonce_valid && !w_push) result_overflow <= 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_tx_state <= TX_IDLE;
            r_tx_shift <= '0;
            r_tx_cmd   <= '0;
            r_tx_csum  <= '0;
            r_tx_cnt   <= '0;
            tx_data    <= '0;
            tx_valid   <= 1'b0;
        end else begin
            unique case (r_tx_state)
                TX_IDLE: begin
`ifdef FRAMER_ACK_EN
                    if (w_ack_take) begin
                        r_tx_shift <= NW'(w_ack_data) << (NW - 8);
                        r_tx_cmd   <= r_ack_pgood ? 8'hA0 : 8'hA1;
                        r_tx_csum  <= r_ack_pgood ? 8'hA0 : 8'hA1;
                        r_tx_cnt   <= DW'(1);
                        tx_data    <= 8'h55;
                        tx_valid   <= 1'b1;
                        r_tx_state <= TX_SYNC;
                    end else
`endif
                    if (w_pop) begin
                        r_tx_shift <= r_fifo[r_rp];
                        r_tx_cmd   <= 8'h10;
                        r_tx_csum  <= 8'h10;
                        r_tx_cnt   <= DW'(NONCE_BYTES);
                        tx_data    <= 8'h55;
                        tx_valid   <= 1'b1;
                        r_tx_state <= TX_SYNC;
                    end
                end
                TX_SYNC: if (tx_ready) begin
                    tx_data    <= r_tx_cmd;
                    r_tx_state <= TX_CMD;
                end
                TX_CMD, TX_DATA: if (tx_ready) begin
                    if (r_tx_cnt == '0) begin
                        tx_data    <= r_tx_csum;
                        r_tx_state <= TX_CSUM;
                    end else begin
                        tx_data    <= r_tx_shift[NW-1 -: 8];
                        r_tx_csum  <= r_tx_csum ^ r_tx_shift[NW-1 -: 8];
                        r_tx_shift <= r_tx_shift << 8;
                        r_tx_cnt   <= r_tx_cnt - DW'(1);
                        r_tx_state <= TX_DATA;
                    end
                end
                TX_CSUM: if (tx_ready) begin
                    tx_valid   <= 1'b0;
                    r_tx_state <= TX_IDLE;
                end
                default: r_tx_state <= TX_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_work_framer.sv
// Directed bench for uart_work_framer (HEADER_BYTES=4, TIMEOUT_CYCLES=100, default build).
module tb_uart_work_framer;
    logic        clock = 1'b0;
    logic        reset;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic [31:0] header_data;
    logic        work_valid;
    logic        abort;
    logic [31:0] nonce_in;
    logic        nonce_valid;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic [15:0] frame_err_count;
    logic        result_overflow;

    always #5 clock = ~clock;

    uart_work_framer #(
        .HEADER_BYTES(4),
        .NONCE_BYTES(4),
        .RESULT_DEPTH(4),
        .TIMEOUT_CYCLES(100)
    ) dut (
        .clock(clock), .reset(reset),
        .rx_data(rx_data), .rx_valid(rx_valid),
        .header_data(header_data), .work_valid(work_valid), .abort(abort),
        .nonce_in(nonce_in), .nonce_valid(nonce_valid),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .frame_err_count(frame_err_count), .result_overflow(result_overflow)
    );

    int          checks = 0;
    int          errors = 0;
    logic        run = 1'b0;
    logic [31:0] exp_header = '0;
    logic [15:0] exp_err = '0;
    logic        exp_wv = 1'b0;
    logic        exp_ab = 1'b0;
    logic        exp_ovf = 1'b0;
    logic [7:0]  exp_tx[$];
    logic [7:0]  tx_log[$];
    logic        prev_stall = 1'b0;
    logic [7:0]  prev_data = '0;
    int          rdy_mode = 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    always @(negedge clock) begin
        if (run) begin
            check("header_data", 64'(header_data), 64'(exp_header));
            check("frame_err_count", 64'(frame_err_count), 64'(exp_err));
            check("work_valid", 64'(work_valid), 64'(exp_wv));
            check("abort", 64'(abort), 64'(exp_ab));
            check("result_overflow", 64'(result_overflow), 64'(exp_ovf));
            if (reset) begin
                if (prev_stall) begin
                    check("tx_valid_held", 64'(tx_valid), 64'd1);
                    check("tx_data_stable", 64'(tx_data), 64'(prev_data));
                end
                if (tx_valid && tx_ready) begin
                    tx_log.push_back(tx_data);
                    if (exp_tx.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL tx_extra_byte actual=%0h required=none", tx_data);
                    end else begin
                        check("tx_byte", 64'(tx_data), 64'(exp_tx.pop_front()));
                    end
                end
                prev_stall = tx_valid && !tx_ready;
                prev_data  = tx_data;
            end else begin
                prev_stall = 1'b0;
            end
        end
    end

    // tx_ready pattern: 0 = stalled, 1 = always ready, 2 = ready one cycle in three.
    initial begin
        int phase = 0;
        tx_ready = 1'b1;
        forever begin
            @(posedge clock);
            #1;
            phase = (phase + 1) % 3;
            case (rdy_mode)
                0:       tx_ready = 1'b0;
                2:       tx_ready = (phase == 0);
                default: tx_ready = 1'b1;
            endcase
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
    endtask

    task automatic send_load(input logic [31:0] hdr, input logic corrupt);
        logic [7:0] cs = 8'h01;
        send_byte(8'hAA);
        send_byte(8'h01);
        for (int i = 3; i >= 0; i--) begin
            cs = cs ^ hdr[i*8 +: 8];
            send_byte(hdr[i*8 +: 8]);
        end
        send_byte(corrupt ? (cs ^ 8'h01) : cs);
        if (corrupt) exp_err++;
        else begin
            exp_header = hdr;
            exp_wv     = 1'b1;
        end
        tick();
        exp_wv = 1'b0;
    endtask

    task automatic push_nonce(input logic [31:0] n, input logic accepted);
        logic [7:0] cs = 8'h10;
        nonce_in    = n;
        nonce_valid = 1'b1;
        if (accepted) begin
            exp_tx.push_back(8'h55);
            exp_tx.push_back(8'h10);
            for (int i = 3; i >= 0; i--) begin
                exp_tx.push_back(n[i*8 +: 8]);
                cs = cs ^ n[i*8 +: 8];
            end
            exp_tx.push_back(cs);
        end
        tick();
        nonce_valid = 1'b0;
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while ((exp_tx.size() != 0 || tx_valid) && n < budget) begin
            tick();
            n++;
        end
        if (n >= budget) begin
            checks++;
            errors++;
            $display("FAIL tx_drain_timeout actual=%0d_bytes_left required=0", exp_tx.size());
        end
        tick();
    endtask

    task automatic do_reset();
        reset = 1'b0;
        tick();
        exp_header = '0;
        exp_err    = '0;
        exp_wv     = 1'b0;
        exp_ab     = 1'b0;
        exp_ovf    = 1'b0;
        exp_tx.delete();
        reset = 1'b1;
    endtask

    initial begin
        logic [7:0] lit [7];
        lit = '{8'h55, 8'h10, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h32};
        reset       = 1'b0;
        rx_data     = '0;
        rx_valid    = 1'b0;
        nonce_in    = '0;
        nonce_valid = 1'b0;
        repeat (2) tick();
        check("rst_tx_valid", 64'(tx_valid), 64'd0);
        check("rst_header", 64'(header_data), 64'd0);
        check("rst_err", 64'(frame_err_count), 64'd0);
        run   = 1'b1;
        reset = 1'b1;
        tick();

        send_load(32'h11223344, 1'b0);
        check("lit_header", 64'(header_data), 64'h11223344);
        send_load(32'h55667788, 1'b1);
        check("lit_bad_csum_err", 64'(frame_err_count), 64'd1);

        send_byte(8'h00);
        send_byte(8'h13);
        send_byte(8'hAA);
        send_byte(8'h02);
        send_byte(8'h02);
        exp_ab = 1'b1;
        tick();
        exp_ab = 1'b0;

        send_byte(8'hAA);
        send_byte(8'h07);
        exp_err++;
        tick();

        send_load(32'hAA010203, 1'b0);

        send_byte(8'hAA);
        send_byte(8'h01);
        send_byte(8'h11);
        repeat (100) @(posedge clock);
        #1;
        exp_err++;
        tick();
        check("lit_timeout_err", 64'(frame_err_count), 64'd3);
        send_load(32'hCAFEF00D, 1'b0);

        tx_log.delete();
        rdy_mode = 1;
        push_nonce(32'hDEADBEEF, 1'b1);
        drain(100);
        check("lit_tx_len", 64'(tx_log.size()), 64'd7);
        for (int i = 0; i < 7 && i < tx_log.size(); i++)
            check("lit_tx_byte", 64'(tx_log[i]), 64'(lit[i]));

        rdy_mode = 2;
        push_nonce(32'hDEADBEEF, 1'b1);
        push_nonce(32'h12345678, 1'b1);
        drain(200);

        rdy_mode = 0;
        tick();
        tick();
        tx_log.delete();
        push_nonce(32'h00000001, 1'b1);
        push_nonce(32'h00000002, 1'b1);
        push_nonce(32'h00000003, 1'b1);
        push_nonce(32'h00000004, 1'b1);
        push_nonce(32'h00000005, 1'b0);
        exp_ovf = 1'b1;
        tick();
        check("lit_overflow", 64'(result_overflow), 64'd1);
        check("lit_stalled_no_tx", 64'(tx_log.size()), 64'd0);
        rdy_mode = 1;
        drain(300);
        check("lit_four_frames", 64'(tx_log.size()), 64'd28);

        push_nonce(32'hA5A5A5A5, 1'b1);
        tick();
        tick();
        rdy_mode = 0;
        send_byte(8'hAA);
        send_byte(8'h01);
        send_byte(8'h11);
        send_byte(8'h22);
        do_reset();
        check("reset_tx_valid", 64'(tx_valid), 64'd0);
        check("reset_work_valid", 64'(work_valid), 64'd0);
        check("reset_err", 64'(frame_err_count), 64'd0);
        rdy_mode = 1;
        tick();
        send_load(32'h0BADF00D, 1'b0);
        check("lit_post_reset_header", 64'(header_data), 64'h0BADF00D);
        push_nonce(32'h01020304, 1'b1);
        drain(100);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end
endmodule
